// File: rtl/mul_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mul_sequencer_pkg                                                |
// | Brief   : State encoding and default sizing for the multi-cycle multiplier |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mul_sequencer_pkg;

  localparam int c_WIDTH = 32;
  localparam int c_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mulState_e;

endpackage : mul_sequencer_pkg
`default_nettype wire

// File: rtl/mul_sequencer_shift_add_dp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mul_shift_add_dp                                                 |
// | Brief   : Radix-2 shift-add datapath (acc/mcand/mplier, ripple adder)      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mul_shift_add_dp
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = c_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [0:WIDTH-1] opA,
  input  logic [0:WIDTH-1] opB,
  output logic [0:WIDTH-1] accNext,
  output logic             mplierZero
);

  logic [0:WIDTH-1] r_acc;
  logic [0:WIDTH-1] r_mcand;
  logic [0:WIDTH-1] r_mplier;
  logic [0:WIDTH-1] w_sum;
  logic [1:WIDTH]   w_carry;

  // Index WIDTH-1 is the LSB, so the carry ripples from high index to low.
  assign w_carry[WIDTH] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign w_sum[i] = r_acc[i] ^ r_mcand[i] ^ w_carry[i+1];
    if (i > 0) begin : g_carry
      assign w_carry[i] = (r_acc[i] & r_mcand[i]) | (w_carry[i+1] & (r_acc[i] ^ r_mcand[i]));
    end
  end

  assign accNext    = r_mplier[WIDTH-1] ? w_sum : r_acc;
  assign mplierZero = ((r_mplier >> 1) == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (load) begin
      r_acc    <= '0;
      r_mcand  <= opA;
      r_mplier <= opB;
    end else if (step) begin
      r_acc    <= accNext;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

endmodule : mul_shift_add_dp
`default_nettype wire

// File: rtl/mul_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mul_sequencer                                                    |
// | Brief   : Execute-stage multi-cycle multiply controller with stall/valid   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = c_WIDTH,
  parameter int CNT_W = c_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mul_in,
  input  logic [0:WIDTH-1] opA_in,
  input  logic [0:WIDTH-1] opB_in,
  input  logic             kill_in,
  output logic             stall_out,
  output logic             busy_out,
  output logic [0:WIDTH-1] result_out,
  output logic             result_valid
);

  mulState_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [0:WIDTH-1] r_result;
  logic             r_busy;
  logic             r_valid;

  logic             w_accept;
  logic             w_step;
  logic             w_finish;
  logic             w_mplierZero;
  logic [0:WIDTH-1] w_accNext;

  // Stall must assert in the accept cycle itself so ID/EX keeps the op.
  assign w_accept  = (r_state == IDLE) & mul_in & ~kill_in;
  assign w_step    = (r_state == RUN) & ~kill_in;
  assign w_finish  = w_step & (w_mplierZero | (r_cnt == CNT_W'(WIDTH - 1)));
  assign stall_out = w_accept | (r_state == RUN);

  assign busy_out     = r_busy;
  assign result_out   = r_result;
  assign result_valid = r_valid;

  mul_shift_add_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk       (clk),
    .reset     (reset),
    .load      (w_accept),
    .step      (w_step),
    .opA       (opA_in),
    .opB       (opB_in),
    .accNext   (w_accNext),
    .mplierZero(w_mplierZero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_valid <= 1'b0;
          if (w_accept) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (kill_in) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_finish) begin
              r_state  <= DONE;
              r_busy   <= 1'b0;
              r_valid  <= 1'b1;
              r_result <= w_accNext;
            end
          end
        end
        DONE: begin
          // The result retires this cycle; mul_in still shows the finished op.
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : mul_sequencer
`default_nettype wire
